// File: rtl/addsub_pkg.sv
// Shared types for the pipelined add/subtract unit: operation mode encoding.
package addsub_pkg;

    typedef enum logic [1:0] {
        MODE_ADD  = 2'b00,
        MODE_SUB  = 2'b01,
        MODE_ADDC = 2'b10,
        MODE_ACC  = 2'b11
    } mode_e;

endpackage

// File: rtl/addsub_pipe_stage.sv
// One valid/ready register slice; data is captured only on a transfer and held otherwise.
module addsub_pipe_stage #(
    parameter int DW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          up_valid,
    input  logic [DW-1:0] up_data,
    input  logic          dn_ready,
    output logic          valid,
    output logic [DW-1:0] data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (!valid || dn_ready) begin
            valid <= up_valid;
            if (up_valid) begin
                data <= up_data;
            end
        end
    end

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined add/sub/add-with-carry/accumulate unit behind a valid/ready register chain.
// Optional signed saturation of results is enabled by defining ADDSUB_PIPE_SAT_EN.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             CLK,
    input  logic             ASYNCRESETN,
    input  logic             I_VALID,
    output logic             I_READY,
    input  logic [1:0]       MODE,
    input  logic             CIN,
    input  logic             ACC_CLR,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    output logic             O_VALID,
    input  logic             O_READY,
    output logic [WIDTH-1:0] O,
    output logic             COUT,
    output logic             V
);

    typedef struct packed {
        logic [WIDTH-1:0] o;
        logic             cout;
        logic             v;
    } result_t;

`ifdef ADDSUB_PIPE_SAT_EN
    localparam logic [WIDTH-1:0] SAT_MAX = {WIDTH{1'b1}} >> 1;
    localparam logic [WIDTH-1:0] SAT_MIN = ~SAT_MAX;
`endif

    mode_e            mode;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin_eff;
    logic [WIDTH:0]   sum;
    result_t          res;
    logic             in_fire;

    logic [STAGES:0]  vld;
    logic [STAGES:0]  rdy;
    result_t          dat [0:STAGES];

    assign mode = mode_e'(MODE);

    always_comb begin
        op_a    = I0;
        op_b    = I1;
        cin_eff = 1'b0;
        case (mode)
            MODE_SUB: begin
                op_b    = ~I1;
                cin_eff = 1'b1;
            end
            MODE_ADDC: cin_eff = CIN;
            MODE_ACC:  op_b    = acc;
            default:   ;
        endcase

        sum      = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, cin_eff};
        res.o    = sum[WIDTH-1:0];
        res.cout = sum[WIDTH];
        res.v    = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
`ifdef ADDSUB_PIPE_SAT_EN
        if (res.v) begin
            res.o = op_a[WIDTH-1] ? SAT_MIN : SAT_MAX;
        end
`endif
        // Accumulator load passes the operand straight through with clean flags.
        if (mode == MODE_ACC && ACC_CLR) begin
            res.o    = I0;
            res.cout = 1'b0;
            res.v    = 1'b0;
        end
    end

    assign in_fire = I_VALID && I_READY;

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            acc <= '0;
        end else if (in_fire && mode == MODE_ACC) begin
            acc <= res.o;
        end
    end

    // Ready ripples back from O_READY; a stage accepts when empty or draining.
    always_comb begin
        rdy         = '0;
        rdy[STAGES] = O_READY;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy[k] = !vld[k+1] || rdy[k+1];
        end
    end

    assign vld[0]  = I_VALID;
    assign dat[0]  = res;
    assign I_READY = rdy[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        addsub_pipe_stage #(
            .DW(WIDTH + 2)
        ) u_stage (
            .clk      (CLK),
            .rst_n    (ASYNCRESETN),
            .up_valid (vld[k]),
            .up_data  (dat[k]),
            .dn_ready (rdy[k+1]),
            .valid    (vld[k+1]),
            .data     (dat[k+1])
        );
    end

    assign O_VALID = vld[STAGES];
    assign O       = dat[STAGES].o;
    assign COUT    = dat[STAGES].cout;
    assign V       = dat[STAGES].v;

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe: directed cases plus randomized traffic against an arithmetic model.
module tb_addsub_pipe;
    import addsub_pkg::*;

    localparam int W      = 8;
    localparam int STAGES = 2;
    localparam int FULL   = 1 << W;
    localparam int HALF   = FULL / 2;

    logic         CLK;
    logic         ASYNCRESETN;
    logic         I_VALID;
    logic         I_READY;
    logic [1:0]   MODE;
    logic         CIN;
    logic         ACC_CLR;
    logic [W-1:0] I0;
    logic [W-1:0] I1;
    logic         O_VALID;
    logic         O_READY;
    logic [W-1:0] O;
    logic         COUT;
    logic         V;

    addsub_pipe #(.WIDTH(W), .STAGES(STAGES)) dut (
        .CLK         (CLK),
        .ASYNCRESETN (ASYNCRESETN),
        .I_VALID     (I_VALID),
        .I_READY     (I_READY),
        .MODE        (MODE),
        .CIN         (CIN),
        .ACC_CLR     (ACC_CLR),
        .I0          (I0),
        .I1          (I1),
        .O_VALID     (O_VALID),
        .O_READY     (O_READY),
        .O           (O),
        .COUT        (COUT),
        .V           (V)
    );

    typedef struct {
        logic [W-1:0] o;
        logic         c;
        logic         v;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   n_out = 0;
    int   m_acc = 0;
    int   bp_mode = 0;
    logic saw_full = 1'b0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running required done");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sx(input int x);
        return (x >= HALF) ? x - FULL : x;
    endfunction

    // Backpressure driver: 0 always ready, 1 random, 2 held off.
    initial begin
        O_READY = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            case (bp_mode)
                1:       O_READY = 1'($urandom_range(0, 1));
                2:       O_READY = 1'b0;
                default: O_READY = 1'b1;
            endcase
        end
    end

    // Monitor and reference model: inputs are stable between negedge and the next posedge.
    int   ma, mb, mu, ms;
    exp_t e;
    always @(negedge CLK) begin
        if (ASYNCRESETN) begin
            chk("i_ready", 32'(I_READY), 32'((q.size() < STAGES) || O_READY));
            if (!I_READY) saw_full = 1'b1;
            if (O_VALID) begin
                if (q.size() == 0) begin
                    chk("spurious_o_valid", 32'(O_VALID), 32'd0);
                end else begin
                    chk("o",    32'(O),    32'(q[0].o));
                    chk("cout", 32'(COUT), 32'(q[0].c));
                    chk("v",    32'(V),    32'(q[0].v));
                    if (O_READY) begin
                        void'(q.pop_front());
                        n_out++;
                    end
                end
            end
            if (I_VALID && I_READY) begin
                ma = int'(I0);
                mb = int'(I1);
                case (MODE)
                    MODE_ADD: begin
                        mu = ma + mb;
                        ms = sx(ma) + sx(mb);
                    end
                    MODE_SUB: begin
                        mu = ma + (FULL - 1 - mb) + 1;
                        ms = sx(ma) - sx(mb);
                    end
                    MODE_ADDC: begin
                        mu = ma + mb + int'(CIN);
                        ms = sx(ma) + sx(mb) + int'(CIN);
                    end
                    default: begin
                        if (ACC_CLR) begin
                            mu = ma;
                            ms = sx(ma);
                        end else begin
                            mu = m_acc + ma;
                            ms = sx(m_acc) + sx(ma);
                        end
                    end
                endcase
                e.o = W'(mu % FULL);
                e.c = (mu >= FULL);
                e.v = (ms > HALF - 1) || (ms < -HALF);
`ifdef ADDSUB_PIPE_SAT_EN
                if (e.v) e.o = (ms > 0) ? W'(HALF - 1) : W'(HALF);
`endif
                if (MODE == MODE_ACC) m_acc = int'(e.o);
                q.push_back(e);
            end
        end
    end

    // Present one operation from posedge+1 and hold it until accepted.
    task automatic send(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic clr);
        logic fired;
        int   n;
        MODE    = m;
        I0      = a;
        I1      = b;
        CIN     = c;
        ACC_CLR = clr;
        I_VALID = 1'b1;
        fired   = 1'b0;
        n       = 0;
        do begin
            @(negedge CLK);
            fired = I_READY;
            @(posedge CLK);
            #1;
            n++;
        end while (!fired && n < 200);
        I_VALID = 1'b0;
        chk("send_accepted", 32'(fired), 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(posedge CLK);
            n++;
        end
        #1;
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        int n0;
        ASYNCRESETN = 1'b0;
        I_VALID     = 1'b0;
        MODE        = 2'b00;
        CIN         = 1'b0;
        ACC_CLR     = 1'b0;
        I0          = '0;
        I1          = '0;
        #1;
        chk("rst_o_valid", 32'(O_VALID), 32'd0);
        chk("rst_o",       32'(O),       32'd0);
        chk("rst_cout",    32'(COUT),    32'd0);
        chk("rst_v",       32'(V),       32'd0);
        chk("rst_acc",     32'(dut.acc), 32'd0);
        #11;
        ASYNCRESETN = 1'b1;
        @(posedge CLK);
        #1;

        // Basic add with carry-out and exact latency.
        send(MODE_ADD, 8'hF0, 8'h20, 1'b0, 1'b0);
        for (int i = 0; i < STAGES - 1; i++) begin
            @(negedge CLK);
            chk("lat_early", 32'(O_VALID), 32'd0);
        end
        @(negedge CLK);
        chk("lat_valid", 32'(O_VALID), 32'd1);
        chk("t1_o",      32'(O),       32'h10);
        chk("t1_cout",   32'(COUT),    32'd1);
        @(posedge CLK);
        #1;
        drain();

        // Subtract, carry-in handling, back-to-back accumulate with an interleaved add.
        send(MODE_SUB,  8'h05, 8'h07, 1'b0, 1'b0);
        send(MODE_SUB,  8'h80, 8'h01, 1'b0, 1'b0);
        send(MODE_ADDC, 8'h7F, 8'h00, 1'b1, 1'b0);
        send(MODE_ADD,  8'h7F, 8'h00, 1'b1, 1'b0);
        send(MODE_ACC,  8'h03, 8'h00, 1'b0, 1'b1);
        send(MODE_ACC,  8'h05, 8'h00, 1'b0, 1'b0);
        send(MODE_ACC,  8'hFF, 8'h00, 1'b0, 1'b0);
        send(MODE_ADD,  8'h01, 8'h01, 1'b0, 1'b0);
        send(MODE_ACC,  8'h01, 8'hAA, 1'b1, 1'b0);
        drain();
        chk("t4_acc", 32'(dut.acc), 32'h08);

        // Stream under a downstream stall.
        n0       = n_out;
        saw_full = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    send(MODE_ADD, W'(i), 8'h10, 1'b0, 1'b0);
                end
            end
            begin
                repeat (3) @(posedge CLK);
                bp_mode = 2;
                repeat (4) @(posedge CLK);
                bp_mode = 0;
            end
        join
        drain();
        chk("t5_count",        32'(n_out - n0), 32'd10);
        chk("t5_backpressure", 32'(saw_full),   32'd1);

        // Randomized traffic with random backpressure and idle gaps.
        bp_mode = 1;
        repeat (300) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge CLK);
                #1;
            end
            send(2'($urandom_range(0, 3)), W'($urandom), W'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
        end
        bp_mode = 0;
        drain();

        // Reset in the middle of a stalled, full pipe.
        bp_mode = 2;
        @(posedge CLK);
        #1;
        send(MODE_ACC, 8'h55, 8'h00, 1'b0, 1'b1);
        send(MODE_ADD, 8'h03, 8'h04, 1'b0, 1'b0);
        @(posedge CLK);
        #2;
        ASYNCRESETN = 1'b0;
        q.delete();
        m_acc = 0;
        #1;
        chk("mid_rst_o_valid", 32'(O_VALID), 32'd0);
        chk("mid_rst_o",       32'(O),       32'd0);
        chk("mid_rst_cout",    32'(COUT),    32'd0);
        chk("mid_rst_v",       32'(V),       32'd0);
        chk("mid_rst_acc",     32'(dut.acc), 32'd0);
        bp_mode = 0;
        repeat (2) @(negedge CLK);
        #3;
        ASYNCRESETN = 1'b1;
        repeat (2) begin
            @(negedge CLK);
            chk("post_rst_idle", 32'(O_VALID), 32'd0);
        end
        @(posedge CLK);
        #1;
        send(MODE_ACC, 8'h04, 8'h00, 1'b0, 1'b0);
        drain();
        chk("post_rst_acc", 32'(dut.acc), 32'h04);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
- Parametrised, pipelined integer add/subtract unit; successor to the fixed 8-bit combinational add-with-carry and subtract blocks.
- Supports four operations: add, subtract, add-with-carry-in, and running accumulate. Produces carry-out and signed-overflow flags.
- Uses a valid/ready elastic pipeline so it drops into streaming datapaths between producer and consumer stages.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1)
- STAGES, 2, number of register stages from input acceptance to output (>=1)

Ports:
- CLK  input  1  clock, rising edge
- ASYNCRESETN  input  1  asynchronous active-low reset
- I_VALID  input  1  input operands valid
- I_READY  output  1  block accepts input this cycle
- MODE  input  2  00 ADD, 01 SUB, 10 ADDC, 11 ACC
- CIN  input  1  carry-in; used in ADDC only
- ACC_CLR  input  1  in ACC mode, load the accumulator instead of adding
- I0  input  WIDTH  operand A
- I1  input  WIDTH  operand B (ignored in ACC)
- O_VALID  output  1  result valid
- O_READY  input  1  downstream accepts result
- O  output  WIDTH  result
- COUT  output  1  unsigned carry-out
- V  output  1  signed overflow

Behaviour:
- Clock and reset: one clock (CLK). Reset is asynchronous and active-low on ASYNCRESETN. While asserted, all stage valids, the accumulator, O, COUT and V are 0.
- Transfer rule: a transfer occurs when VALID && READY on the same edge. Input operands are sampled only on an input transfer.
- Arithmetic (stage 0), done at WIDTH+1 bits:
  - ADD: {COUT,O} = I0 + I1
  - SUB: {COUT,O} = I0 + ~I1 + 1. COUT=1 means no borrow.
  - ADDC: {COUT,O} = I0 + I1 + CIN
  - ACC with ACC_CLR=1: acc <= I0, O = I0, COUT=0, V=0
  - ACC with ACC_CLR=0: {COUT,O} = acc + I0, acc <= O
  - CIN is ignored outside ADDC.
- Overflow: V = (a[MSB]==b[MSB]) && (O[MSB]!=a[MSB]), where b is the effective second operand (~I1 for SUB, acc for ACC).
- Accumulator update: acc updates only on an accepted ACC-mode transfer. It wraps modulo 2^WIDTH. Non-ACC operations leave acc unchanged.
- Pipeline: STAGES register stages, each holding {valid, O, COUT, V}.
  - Stage k ready = !valid[k] || ready[k+1]; the last stage uses O_READY.
  - I_READY = stage-0 ready, which is combinational from O_READY through the stall chain.
  - Latency is exactly STAGES cycles when unstalled. Throughput is 1 per cycle.
- Backpressure: with O_READY=0, O/COUT/V hold stable while O_VALID=1. Bubbles collapse. I_READY deasserts only when all STAGES entries are valid. No loss or duplication.
- Simultaneous events: a full pipe with O_READY=1 and I_VALID=1 accepts and emits on the same edge.
- Mid-operation reset: all in-flight results are discarded and acc returns to 0. The output must not assert O_VALID until a new input has traversed STAGES cycles after reset release.
- Outputs are registered. O_VALID=0 implies O/COUT/V hold their last value and are don't-care.

Optional Feature:
- Macro: ADDSUB_PIPE_SAT_EN.
- Defined: for ADD, SUB and ADDC, when V=1, O saturates to the signed limit in the direction of the operand sign (0x7F.. or 0x80..). V still reports 1. In ACC mode the saturated value is also written into acc.
- Undefined: results wrap modulo 2^WIDTH. Saturation logic is absent.

Decomposition:
- Package addsub_pkg holds:
  - the mode_e enum (MODE_ADD=2'b00, MODE_SUB=2'b01, MODE_ADDC=2'b10, MODE_ACC=2'b11)
  - the result struct typedef {O, COUT, V}, parametrised through WIDTH in the module
- One sub-module, addsub_pipe_stage: a single valid/ready register slice, instantiated STAGES times in a generate loop.
- The arithmetic core stays in the top level as combinational logic.

Test Plan (WIDTH=8, STAGES=2):
1. ADD I0=0xF0, I1=0x20, O_READY=1 -> 2 cycles later O=0x10, COUT=1, V=0, O_VALID pulses once.
2. SUB I0=0x05, I1=0x07 -> O=0xFE, COUT=0, V=0. Then SUB 0x80-0x01 -> O=0x7F, V=1 (with SAT_EN defined: O=0x80, V=1).
3. ADDC I0=0x7F, I1=0x00, CIN=1 -> O=0x80, COUT=0, V=1. Repeat in ADD mode with CIN=1 -> O=0x7F (CIN ignored).
4. ACC sequence, back-to-back:
   - load 0x03 (ACC_CLR=1) -> O=0x03
   - add 0x05 -> O=0x08
   - add 0xFF -> O=0x07, COUT=1
   - interleaved ADD 1+1 -> O=0x02; a following ACC add 0x01 yields O=0x08
5. Stream 10 incrementing ADD ops with O_READY held 0 for cycles 3-6 -> I_READY drops after 2 accepted-but-unconsumed entries. All 10 results arrive in order, none dropped or duplicated, O stable while stalled.
6. Assert ASYNCRESETN=0 mid-stream, off-clock-edge -> O_VALID, O, COUT, V and acc go to 0 immediately. After release, the first ACC add 0x04 yields O=0x04.
